// File: rtl/mmio_fabric_pkg.sv
// rtl/mmio_fabric_pkg.sv - shared state encoding, window-width helper and channel map for mmio_fabric
package mmio_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index width of the I/O window; never narrower than one bit.
  function automatic int cw_of(input int nch);
    return (nch < 2) ? 1 : $clog2(nch);
  endfunction

  localparam int CH_EXTRAM    = 0;
  localparam int CH_STATUS    = 1;
  localparam int CH_ADDRSTACK = 2;
  localparam int CH_USERSTACK = 3;
  localparam int CH_UART      = 4;
  localparam int CH_GPIO      = 5;
  localparam int CH_GPIODIR   = 6;

endpackage

// File: rtl/mmio_decode.sv
// rtl/mmio_decode.sv - combinational address decode into window hit, channel index and one-hot select
module mmio_decode
  import mmio_fabric_pkg::*;
#(
  parameter int            NCH    = 8,
  parameter int            AW     = 16,
  parameter int            CW     = 3,
  parameter logic [AW-1:0] BASE   = 16'hFF00,
  parameter int            DEF_CH = 0
) (
  input  logic [AW-1:0]  addr,
  output logic           hit,
  output logic [CW-1:0]  ch,
  output logic [NCH-1:0] sel
);

  localparam logic [CW:0]   NCH_W = (CW+1)'(NCH);
  localparam logic [CW-1:0] DEF_W = CW'(DEF_CH);

  logic in_win;
  logic idx_ok;

  // Window slots beyond the last real channel fall through to the default channel.
  always_comb begin
    in_win = (addr[AW-1:CW] == BASE[AW-1:CW]);
    idx_ok = ({1'b0, addr[CW-1:0]} < NCH_W);
    hit    = in_win && idx_ok;
    ch     = hit ? addr[CW-1:0] : DEF_W;
    sel    = '0;
    for (int i = 0; i < NCH; i++) begin
      sel[i] = (ch == CW'(i));
    end
  end

endmodule

// File: rtl/mmio_fabric.sv
// rtl/mmio_fabric.sv - registered request/ack MMIO router; optional bus timeout via MMIO_TIMEOUT_EN
module mmio_fabric
  import mmio_fabric_pkg::*;
#(
  parameter int            NCH     = 8,
  parameter int            DW      = 16,
  parameter int            AW      = 16,
  parameter logic [AW-1:0] BASE    = 16'hFF00,
  parameter int            DEF_CH  = 0,
  parameter int            TIMEOUT = 15
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [DW-1:0]          cpu_wdata,
  output logic [DW-1:0]          cpu_rdata,
  output logic                   cpu_ready,
  output logic                   cpu_err,
  output logic [NCH-1:0]         per_sel,
  output logic                   per_we,
  output logic [cw_of(NCH)-1:0]  per_addr,
  output logic [DW-1:0]          per_wdata,
  input  logic [NCH*DW-1:0]      per_rdata,
  input  logic [NCH-1:0]         per_ack
);

  localparam int            CW    = cw_of(NCH);
  localparam logic [CW-1:0] DEF_W = CW'(DEF_CH);

  state_e          state_q, state_d;
  logic [NCH-1:0]  sel_q, sel_d;
  logic            we_q, we_d;
  logic [CW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready_q, ready_d;

  logic            dec_hit;
  logic [CW-1:0]   dec_ch;
  logic [NCH-1:0]  dec_sel;
  logic            ack_hit;
  logic [DW-1:0]   rd_sel;

  mmio_decode #(
    .NCH    (NCH),
    .AW     (AW),
    .CW     (CW),
    .BASE   (BASE),
    .DEF_CH (DEF_CH)
  ) u_decode (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .ch   (dec_ch),
    .sel  (dec_sel)
  );

  assign ack_hit = per_ack[ch_q];
  assign rd_sel  = per_rdata[int'(ch_q)*DW +: DW];

`ifdef MMIO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] cnt_inc;
  logic          err_q, err_d;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ch_d    = ch_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
`ifdef MMIO_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          sel_d   = dec_sel;
          we_d    = cpu_we;
          addr_d  = cpu_addr[CW-1:0];
          wdata_d = cpu_wdata;
          ch_d    = dec_hit ? dec_ch : DEF_W;
          state_d = WAIT;
`ifdef MMIO_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (ack_hit) begin
          rdata_d = we_q ? '0 : rd_sel;
          sel_d   = '0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ready_d = 1'b1;
          state_d = DONE;
`ifdef MMIO_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_inc == TW'(TIMEOUT)) begin
          // Ack has priority above; reaching here means the peripheral never answered.
          rdata_d = '0;
          sel_d   = '0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_inc;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MMIO_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ch_q    <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ch_q    <= ch_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
`ifdef MMIO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign per_sel   = sel_q;
  assign per_we    = we_q;
  assign per_addr  = addr_q;
  assign per_wdata = wdata_q;
`ifdef MMIO_TIMEOUT_EN
  assign cpu_err   = err_q;
`else
  assign cpu_err   = 1'b0;
`endif

endmodule
